op_dispatcher: RTL
==================

# op_dispatcher

Front-end stage of the priority calculator: accepts a single stream of tagged arithmetic commands and routes each one to the add, sub or mul unit's valid/ack request port. Commands are buffered in a small in-order FIFO, and only one unit request is outstanding at any time. Illegal opcodes are dropped and counted. The block sits directly upstream of the calculator core and drives its `add_*`, `sub_*` and `mul_*` inputs.

## Interface
- `WIDTH`, default 64: operand width.
- `DEPTH`, default 4: command FIFO entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_op` in 2: opcode (0 add, 1 sub, 2 mul, 3 illegal).
- `cmd_a`, `cmd_b` in WIDTH: operands.
- `add_valid` out 1, `add_ack` in 1, `add_a`/`add_b` out WIDTH: add unit request.
- `sub_valid` out 1, `sub_ack` in 1, `sub_a`/`sub_b` out WIDTH: sub unit request.
- `mul_valid` out 1, `mul_ack` in 1, `mul_a`/`mul_b` out WIDTH: mul unit request.
- `fifo_level` out $clog2(DEPTH+1): FIFO occupancy.
- `drop_count` out 16: illegal commands dropped, saturating.

## Operation
- Input handshake:
  - A command is written at a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = (fifo_level < DEPTH)`, decoded from registered level only.
  - There is no pass-through when full: a pop in the same cycle does not raise `cmd_ready`.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop leave `fifo_level` unchanged.
- Holding register: `hold_op`, `hold_a`, `hold_b`. All three units' `*_a`/`*_b` outputs are driven from `hold_a`/`hold_b`.
- FSM states: IDLE, ISSUE.
  - IDLE, FIFO empty: stay IDLE.
  - IDLE, head op in 0..2: pop the head into the holding register and go to ISSUE.
  - IDLE, head op == 3: pop and discard; `drop_count` +1, saturating at 0xFFFF; stay IDLE; no unit valid asserted.
  - ISSUE: exactly the one `*_valid` selected by `hold_op` is high. Operands are stable until ack.
  - ISSUE, matching `*_ack` sampled high at an edge: go to IDLE. Valid is low the following cycle.
  - ISSUE, no matching ack: stay in ISSUE.
- Acks from non-selected units, and any ack while in IDLE, are ignored.
- Commands issue strictly in acceptance order. A stalled unit blocks all later commands (head-of-line).
- Reset (asynchronous, at any time, including mid-ISSUE):
  - FSM goes to IDLE and pointers clear.
  - All `*_valid` = 0, `*_a`/`*_b` = 0, `fifo_level` = 0, `drop_count` = 0.
  - `cmd_ready` = 1 once reset is released.
  - An in-flight request is abandoned and is not replayed.

## Timing
- Accept-to-request latency is 2 cycles:
  - Command accepted at edge N.
  - Head is visible in IDLE during cycle N+1, and the pop happens at edge N+1.
  - `*_valid` is high in cycle N+2.
- Ack is sampled at an edge where valid is high; valid is low from the next cycle.
- Minimum one idle cycle between consecutive requests. Peak throughput is 1 command per 2 cycles with a zero-wait ack (ack high in the first ISSUE cycle).
- Illegal-op drops consume 1 IDLE cycle each.
- `fifo_level` and `drop_count` update at the edge of the push/pop/drop event.
- All outputs are registered or decoded from registered state only. There is no combinational path from `*_ack` or `cmd_valid` to any output.

## Test plan
- Single add: push op 0, a=5, b=7, with `add_ack` tied high.
  - Required: `add_valid` high exactly one cycle, 2 cycles after accept, with `add_a`=5, `add_b`=7.
  - Required: `sub_valid` and `mul_valid` stay 0; `fifo_level` returns to 0.
- Ordering and back-pressure: push add, sub, mul, add back-to-back (DEPTH=4) with all acks held low.
  - Required: after the first pop, `fifo_level` = 3; a 5th push is accepted, then `cmd_ready` = 0 at level 4.
  - Release acks: required issue order add, sub, mul, add, with a ≥1-cycle valid-low gap between requests.
- Ack stall: hold `mul_ack` low 10 cycles during a mul issue.
  - Required: `mul_valid` and operands stay stable for all 10 cycles.
  - Required: a stray `add_ack` pulse during the stall is ignored; the FSM leaves ISSUE only on `mul_ack`.
- Illegal op: push op 3, then op 1 (a=9, b=4).
  - Required: no valid asserted for the op 3 command; `drop_count` = 1; `sub_valid` for the op 1 command rises 1 cycle later than it would without the drop.
  - Preload `drop_count` at 0xFFFF and push op 3: required `drop_count` remains 0xFFFF.
- Wrap-around: stream 3×DEPTH commands with random ack delays.
  - Required: every command is issued exactly once, in order, with its operands intact.
- Reset mid-operation: assert `rst_n` low during ISSUE with level 2.
  - Required: all valids drop asynchronously, `fifo_level` = 0, `cmd_ready` = 1 after release.
  - Required: no stale command is issued after release.

Source files
------------

// File: rtl/op_dispatcher.sv
// Command front-end for the priority calculator: buffers tagged commands in an
// in-order FIFO and issues them one at a time to the add/sub/mul request ports.
module op_dispatcher #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [WIDTH-1:0]               cmd_a,
    input  logic [WIDTH-1:0]               cmd_b,
    output logic                           add_valid,
    input  logic                           add_ack,
    output logic [WIDTH-1:0]               add_a,
    output logic [WIDTH-1:0]               add_b,
    output logic                           sub_valid,
    input  logic                           sub_ack,
    output logic [WIDTH-1:0]               sub_a,
    output logic [WIDTH-1:0]               sub_b,
    output logic                           mul_valid,
    input  logic                           mul_ack,
    output logic [WIDTH-1:0]               mul_a,
    output logic [WIDTH-1:0]               mul_b,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_level,
    output logic [15:0]                    drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    logic [0:0]       state;
    logic [1:0]       mem_op [DEPTH];
    logic [WIDTH-1:0] mem_a  [DEPTH];
    logic [WIDTH-1:0] mem_b  [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [1:0]       hold_op;
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;
    logic [15:0]      drop_cnt;

    logic             push;
    logic             pop;
    logic [1:0]       head_op;
    logic             acked;

    // Ready is decoded from the registered level only, so a same-cycle pop
    // never lets a push through when full.
    assign cmd_ready = (level < LW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (level != '0);
    assign head_op   = mem_op[rd_ptr];

    always_comb begin
        acked = 1'b0;
        unique case (hold_op)
            OP_ADD:  acked = add_ack;
            OP_SUB:  acked = sub_ack;
            OP_MUL:  acked = mul_ack;
            default: acked = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr] <= cmd_op;
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_op  <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
            drop_cnt <= '0;
        end else if (state == IDLE) begin
            if (pop) begin
                if (head_op == OP_ILL) begin
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
                end else begin
                    hold_op <= head_op;
                    hold_a  <= mem_a[rd_ptr];
                    hold_b  <= mem_b[rd_ptr];
                    state   <= ISSUE;
                end
            end
        end else begin
            if (acked) state <= IDLE;
        end
    end

    assign add_valid  = (state == ISSUE) && (hold_op == OP_ADD);
    assign sub_valid  = (state == ISSUE) && (hold_op == OP_SUB);
    assign mul_valid  = (state == ISSUE) && (hold_op == OP_MUL);
    assign add_a      = hold_a;
    assign add_b      = hold_b;
    assign sub_a      = hold_a;
    assign sub_b      = hold_b;
    assign mul_a      = hold_a;
    assign mul_b      = hold_b;
    assign fifo_level = level;
    assign drop_count = drop_cnt;

endmodule
